// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings and response record for the data memory pipe
package dmem_pkg;

  // Access size encodings carried on req_size
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  // One slot of the response pipeline
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

endpackage

// File: rtl/dmem_fmt.sv
// rtl/dmem_fmt.sv - store lane alignment and load extraction/extension (DMEM_ALIGN_CHECK_EN adds misalignment faults)
module dmem_fmt
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata,
  output logic        fault
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sel_b = rword[{addr_lo, 3'b000} +: 8];
  assign sel_h = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Lane enables, replicated store data and extended load data; a fault kills both
  always_comb begin
    be       = 4'b0000;
    wdata_al = wdata;
    rdata    = rword;
    fault    = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    fault = (size == SZ_RSV) ||
            ((size == SZ_H) && addr_lo[0]) ||
            ((size == SZ_W) && (addr_lo != 2'b00));
`endif
    case (size)
      SZ_B: begin
        be       = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
        rdata    = {{24{!uns && sel_b[7]}}, sel_b};
      end
      SZ_H: begin
        // addr_lo[0] is ignored here: either faulted above or treated as aligned
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata[15:0]}};
        rdata    = {{16{!uns && sel_h[15]}}, sel_h};
      end
      default: begin
        // Word and reserved size both behave as a full word access
        be       = 4'b1111;
        wdata_al = wdata;
        rdata    = rword;
      end
    endcase
    if (fault) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - word-array data memory with in-order LATENCY-deep response pipeline (option: DMEM_ALIGN_CHECK_EN)
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  rsp_t          pipe [LATENCY];
  rsp_t          nxt;
  logic          stall;
  logic          accept;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_al;
  logic [31:0]   ld_data;
  logic          fault;
  logic          unused_addr_hi;

  // Output stall freezes every stage and blocks new requests
  assign stall     = pipe[LATENCY-1].valid && !rsp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;

  // Upper address bits do not select anything, so the array aliases modulo 4*DEPTH
  assign idx            = req_addr[AW+1:2];
  assign unused_addr_hi = ^req_addr[31:AW+2];

  dmem_fmt u_fmt (
    .size     (size_e'(req_size)),
    .uns      (req_unsigned),
    .addr_lo  (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wdata_al (wdata_al),
    .rdata    (ld_data),
    .fault    (fault)
  );

  // Entry into the first stage: stores and faults carry zero data
  always_comb begin
    nxt       = '0;
    nxt.valid = accept;
    nxt.fault = accept && fault;
    nxt.rdata = (accept && !req_we && !fault) ? ld_data : 32'h0;
  end

  // Byte-lane store on the acceptance edge; array itself is never reset
  always_ff @(posedge clk) begin
    if (reset_n && accept && req_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  // Response shift pipeline, advancing only when the output is not stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= nxt;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_valid = pipe[LATENCY-1].valid;
  assign rsp_rdata = pipe[LATENCY-1].rdata;
  assign rsp_fault = pipe[LATENCY-1].fault;

endmodule
